// File: rtl/ocl_mmio_slave.sv
// ocl_mmio_slave
//   AXI4-Lite responder for the host OCL management port. Host peeks and
//   pokes are decoded into a bank of NREG read/write control registers
//   followed by NREG read-only status registers. Every accepted poke to a
//   control register raises a one-cycle strobe on wr_pulse for that register.
//
//   Word index idx = addr[ADDR_W-1:2]:
//     idx <  NREG          control register idx       (RW)
//     NREG <= idx < 2*NREG status register idx-NREG   (RO, poke -> SLVERR)
//     otherwise            unmapped                   (DECERR, rdata 0)
//
// Ports
//   clock, reset          sole clock, synchronous active-high reset
//   s_aw*, s_w*, s_b*     AXI4-Lite write address / data / response channels
//   s_ar*, s_r*           AXI4-Lite read address / data channels
//   ctrl_q                flat control register contents, reg i at [32*i +: 32]
//   status_i              flat status inputs, same packing
//   wr_pulse              bit i high for one cycle when control reg i is poked
//
// Write FSM
//   state    | meaning
//   W_IDLE   | collecting AW and W in any order; each one is held once taken
//   W_COMMIT | both held; decode, update control reg, pick response code
//   W_RESP   | s_bvalid high, waiting for s_bready
//
// The read path is a separate single-outstanding engine and never waits
// on the write FSM. All outputs come straight from flops.
//
// ADDR_W must leave room for at least one bit above the decoded range,
// i.e. ADDR_W - 2 > $clog2(NREG).

module ocl_mmio_slave #(
    parameter int ADDR_W = 16,
    parameter int NREG   = 16
) (
    input  logic                   clock,
    input  logic                   reset,

    input  logic [ADDR_W-1:0]      s_awaddr,
    input  logic                   s_awvalid,
    output logic                   s_awready,
    input  logic [31:0]            s_wdata,
    input  logic [3:0]             s_wstrb,
    input  logic                   s_wvalid,
    output logic                   s_wready,
    output logic [1:0]             s_bresp,
    output logic                   s_bvalid,
    input  logic                   s_bready,

    input  logic [ADDR_W-1:0]      s_araddr,
    input  logic                   s_arvalid,
    output logic                   s_arready,
    output logic [31:0]            s_rdata,
    output logic [1:0]             s_rresp,
    output logic                   s_rvalid,
    input  logic                   s_rready,

    output logic [32*NREG-1:0]     ctrl_q,
    input  logic [32*NREG-1:0]     status_i,
    output logic [NREG-1:0]        wr_pulse
);

    localparam int IDXW = ADDR_W - 2;
    localparam int IW   = $clog2(NREG);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE,
        W_COMMIT,
        W_RESP
    } wstate_t;

    wstate_t             wstate;

    logic [ADDR_W-1:0]   aw_addr_h;
    logic [31:0]         w_data_h;
    logic [3:0]          w_strb_h;
    logic                aw_held;
    logic                w_held;

    logic                aw_hs;
    logic                w_hs;
    logic                ar_hs;
    logic                have_aw;
    logic                have_w;

    logic [IDXW-1:0]     w_idx;
    logic                w_mapped;
    logic                w_ctrl;
    logic                w_stat;

    logic [IDXW-1:0]     r_idx;
    logic                r_mapped;
    logic                r_ctrl;
    logic [31:0]         r_ctrl_word;
    logic [31:0]         r_stat_word;

    // ------------------------------------------------------------------
    // Handshakes and address decode
    // ------------------------------------------------------------------
    // The readies are registered and only ever high in W_IDLE for a channel
    // that has not been taken yet, so valid&ready alone marks a capture.
    always_comb begin
        aw_hs   = s_awvalid & s_awready;
        w_hs    = s_wvalid  & s_wready;
        ar_hs   = s_arvalid & s_arready;
        have_aw = aw_held | aw_hs;
        have_w  = w_held  | w_hs;
    end

    // Shifting the whole address keeps the ignored byte-offset bits part of
    // the expression; bit IW of the word index splits control from status
    // and everything above it must be zero for a mapped access.
    always_comb begin
        w_idx    = IDXW'(aw_addr_h >> 2);
        w_mapped = ((w_idx >> (IW + 1)) == '0);
        w_ctrl   = w_mapped & ~w_idx[IW];
        w_stat   = w_mapped &  w_idx[IW];

        r_idx    = IDXW'(s_araddr >> 2);
        r_mapped = ((r_idx >> (IW + 1)) == '0);
        r_ctrl   = r_mapped & ~r_idx[IW];
    end

    always_comb begin
        r_ctrl_word = '0;
        r_stat_word = '0;
        for (int i = 0; i < NREG; i++) begin
            if (r_idx[IW-1:0] == IW'(i)) begin
                r_ctrl_word = ctrl_q[32*i +: 32];
                r_stat_word = status_i[32*i +: 32];
            end
        end
    end

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            wstate    <= W_IDLE;
            aw_addr_h <= '0;
            w_data_h  <= '0;
            w_strb_h  <= '0;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            s_awready <= 1'b0;
            s_wready  <= 1'b0;
            s_bvalid  <= 1'b0;
            s_bresp   <= RESP_OKAY;
            ctrl_q    <= '0;
            wr_pulse  <= '0;
        end else begin
            wr_pulse <= '0;
            case (wstate)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_addr_h <= s_awaddr;
                        aw_held   <= 1'b1;
                    end
                    if (w_hs) begin
                        w_data_h <= s_wdata;
                        w_strb_h <= s_wstrb;
                        w_held   <= 1'b1;
                    end
                    if (have_aw && have_w) begin
                        wstate    <= W_COMMIT;
                        s_awready <= 1'b0;
                        s_wready  <= 1'b0;
                    end else begin
                        s_awready <= ~have_aw;
                        s_wready  <= ~have_w;
                    end
                end

                W_COMMIT: begin
                    if (w_ctrl) begin
                        s_bresp <= RESP_OKAY;
                        for (int i = 0; i < NREG; i++) begin
                            if (w_idx[IW-1:0] == IW'(i)) begin
                                // Strobe fires even for an all-zero wstrb.
                                wr_pulse[i] <= 1'b1;
                                for (int k = 0; k < 4; k++) begin
                                    if (w_strb_h[k]) begin
                                        ctrl_q[32*i + 8*k +: 8] <= w_data_h[8*k +: 8];
                                    end
                                end
                            end
                        end
                    end else if (w_stat) begin
                        s_bresp <= RESP_SLVERR;
                    end else begin
                        s_bresp <= RESP_DECERR;
                    end
                    s_bvalid <= 1'b1;
                    wstate   <= W_RESP;
                end

                W_RESP: begin
                    if (s_bready) begin
                        s_bvalid  <= 1'b0;
                        aw_held   <= 1'b0;
                        w_held    <= 1'b0;
                        s_awready <= 1'b1;
                        s_wready  <= 1'b1;
                        wstate    <= W_IDLE;
                    end
                end

                default: begin
                    wstate <= W_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    // Read data is taken from ctrl_q as it stands in the handshake cycle, so
    // a read that coincides with a COMMIT to the same register returns the
    // value from before the update.
    always_ff @(posedge clock) begin
        if (reset) begin
            s_arready <= 1'b0;
            s_rvalid  <= 1'b0;
            s_rdata   <= '0;
            s_rresp   <= RESP_OKAY;
        end else if (s_rvalid) begin
            if (s_rready) begin
                s_rvalid  <= 1'b0;
                s_arready <= 1'b1;
            end
        end else if (ar_hs) begin
            s_rvalid  <= 1'b1;
            s_arready <= 1'b0;
            if (!r_mapped) begin
                s_rdata <= '0;
                s_rresp <= RESP_DECERR;
            end else if (r_ctrl) begin
                s_rdata <= r_ctrl_word;
                s_rresp <= RESP_OKAY;
            end else begin
                s_rdata <= r_stat_word;
                s_rresp <= RESP_OKAY;
            end
        end else begin
            s_arready <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ocl_mmio_slave.sv
// Directed bench for ocl_mmio_slave with the default 16-register map.
module tb_ocl_mmio_slave;

    localparam int ADDR_W = 16;
    localparam int NREG   = 16;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic [ADDR_W-1:0]    s_awaddr = '0;
    logic                 s_awvalid = 1'b0;
    logic                 s_awready;
    logic [31:0]          s_wdata = '0;
    logic [3:0]           s_wstrb = '0;
    logic                 s_wvalid = 1'b0;
    logic                 s_wready;
    logic [1:0]           s_bresp;
    logic                 s_bvalid;
    logic                 s_bready = 1'b0;
    logic [ADDR_W-1:0]    s_araddr = '0;
    logic                 s_arvalid = 1'b0;
    logic                 s_arready;
    logic [31:0]          s_rdata;
    logic [1:0]           s_rresp;
    logic                 s_rvalid;
    logic                 s_rready = 1'b0;
    logic [32*NREG-1:0]   ctrl_q;
    logic [32*NREG-1:0]   status_i = '0;
    logic [NREG-1:0]      wr_pulse;

    ocl_mmio_slave #(.ADDR_W(ADDR_W), .NREG(NREG)) dut (
        .clock     (clock),
        .reset     (reset),
        .s_awaddr  (s_awaddr),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_bresp   (s_bresp),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .s_araddr  (s_araddr),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .ctrl_q    (ctrl_q),
        .status_i  (status_i),
        .wr_pulse  (wr_pulse)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] cw(input int i);
        return ctrl_q[32*i +: 32];
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [31:0] d, input logic [3:0] st,
                        output logic [1:0] resp, output logic [15:0] pulse);
        int   n;
        logic aw_go;
        logic w_go;
        s_awaddr = a; s_awvalid = 1'b1;
        s_wdata  = d; s_wstrb   = st; s_wvalid = 1'b1;
        n = 0;
        while ((s_awvalid || s_wvalid) && n < 40) begin
            aw_go = s_awready;
            w_go  = s_wready;
            tick(1);
            n++;
            if (aw_go) s_awvalid = 1'b0;
            if (w_go)  s_wvalid  = 1'b0;
        end
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        n = 0;
        while (!s_bvalid && n < 40) begin
            tick(1);
            n++;
        end
        chk("poke_bvalid", 32'(s_bvalid), 32'd1);
        resp  = s_bresp;
        pulse = wr_pulse;
        s_bready = 1'b1;
        tick(1);
        s_bready = 1'b0;
    endtask

    task automatic peek(input logic [15:0] a, output logic [31:0] data, output logic [1:0] resp);
        int   n;
        logic go;
        s_araddr = a; s_arvalid = 1'b1;
        n = 0; go = 1'b0;
        while (!go && n < 40) begin
            go = s_arready;
            tick(1);
            n++;
        end
        s_arvalid = 1'b0;
        n = 0;
        while (!s_rvalid && n < 40) begin
            tick(1);
            n++;
        end
        chk("peek_rvalid", 32'(s_rvalid), 32'd1);
        data = s_rdata;
        resp = s_rresp;
        s_rready = 1'b1;
        tick(1);
        s_rready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  resp;
        logic [15:0] pulse;
        logic [31:0] data;

        status_i[32*2 +: 32]  = 32'hCAFE0002;
        status_i[32*15 +: 32] = 32'h0F0F_0F0F;

        // Reset state
        tick(3);
        chk("rst_ctrl_any", 32'(|ctrl_q), 32'd0);
        chk("rst_awready",  32'(s_awready), 32'd0);
        chk("rst_wready",   32'(s_wready), 32'd0);
        chk("rst_arready",  32'(s_arready), 32'd0);
        chk("rst_bvalid",   32'(s_bvalid), 32'd0);
        chk("rst_rvalid",   32'(s_rvalid), 32'd0);
        chk("rst_rdata",    s_rdata, 32'd0);
        chk("rst_pulse",    32'(wr_pulse), 32'd0);
        reset = 1'b0;
        tick(1);
        chk("rdy_awready", 32'(s_awready), 32'd1);
        chk("rdy_wready",  32'(s_wready), 32'd1);
        chk("rdy_arready", 32'(s_arready), 32'd1);

        // AW and W together to reg 1; check cycle-accurate latency
        s_awaddr = 16'h0004; s_awvalid = 1'b1;
        s_wdata = 32'hDEADBEEF; s_wstrb = 4'hF; s_wvalid = 1'b1;
        tick(1);
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        chk("t1_commit_bvalid", 32'(s_bvalid), 32'd0);
        chk("t1_commit_pulse",  32'(wr_pulse), 32'd0);
        chk("t1_commit_awrdy",  32'(s_awready), 32'd0);
        tick(1);
        chk("t1_bvalid", 32'(s_bvalid), 32'd1);
        chk("t1_bresp",  32'(s_bresp), 32'd0);
        chk("t1_pulse",  32'(wr_pulse), 32'h0002);
        chk("t1_reg1",   cw(1), 32'hDEADBEEF);
        s_bready = 1'b1;
        tick(1);
        s_bready = 1'b0;
        chk("t1_pulse_gone", 32'(wr_pulse), 32'd0);
        chk("t1_bvalid_gone", 32'(s_bvalid), 32'd0);
        chk("t1_awrdy_back", 32'(s_awready), 32'd1);
        peek(16'h0004, data, resp);
        chk("t1_peek_data", data, 32'hDEADBEEF);
        chk("t1_peek_resp", 32'(resp), 32'd0);

        // W three cycles ahead of AW, partial strobes on reg 0
        poke(16'h0000, 32'hFFFFFFFF, 4'hF, resp, pulse);
        chk("t2_pre_resp",  32'(resp), 32'd0);
        chk("t2_pre_pulse", 32'(pulse), 32'h0001);
        s_wdata = 32'h12345678; s_wstrb = 4'h3; s_wvalid = 1'b1;
        tick(1);
        s_wvalid = 1'b0;
        chk("t2_wready_drop", 32'(s_wready), 32'd0);
        chk("t2_awready_up",  32'(s_awready), 32'd1);
        tick(2);
        chk("t2_no_bvalid", 32'(s_bvalid), 32'd0);
        chk("t2_reg0_hold", cw(0), 32'hFFFFFFFF);
        s_awaddr = 16'h0000; s_awvalid = 1'b1;
        tick(1);
        s_awvalid = 1'b0;
        tick(1);
        chk("t2_bvalid", 32'(s_bvalid), 32'd1);
        chk("t2_bresp",  32'(s_bresp), 32'd0);
        chk("t2_reg0",   cw(0), 32'hFFFF5678);
        s_bready = 1'b1;
        tick(1);
        s_bready = 1'b0;

        // Status window
        peek(16'h0048, data, resp);
        chk("t3_stat_data", data, 32'hCAFE0002);
        chk("t3_stat_resp", 32'(resp), 32'd0);
        poke(16'h0048, 32'h00001234, 4'hF, resp, pulse);
        chk("t3_poke_resp",  32'(resp), 32'h2);
        chk("t3_poke_pulse", 32'(pulse), 32'd0);
        chk("t3_reg2",       cw(2), 32'd0);
        chk("t3_reg1",       cw(1), 32'hDEADBEEF);

        // Map edges and unmapped space
        peek(16'h003C, data, resp);
        chk("b_reg15_data", data, 32'd0);
        chk("b_reg15_resp", 32'(resp), 32'd0);
        peek(16'h007C, data, resp);
        chk("b_stat15_data", data, 32'h0F0F0F0F);
        chk("b_stat15_resp", 32'(resp), 32'd0);
        peek(16'h0080, data, resp);
        chk("b_0080_data", data, 32'd0);
        chk("b_0080_resp", 32'(resp), 32'h3);
        peek(16'h0100, data, resp);
        chk("t4_peek_data", data, 32'd0);
        chk("t4_peek_resp", 32'(resp), 32'h3);
        poke(16'h0100, 32'h55555555, 4'hF, resp, pulse);
        chk("t4_poke_resp",  32'(resp), 32'h3);
        chk("t4_poke_pulse", 32'(pulse), 32'd0);

        // Zero strobe still pulses, value untouched
        poke(16'h000C, 32'hFFFFFFFF, 4'h0, resp, pulse);
        chk("z_resp",  32'(resp), 32'd0);
        chk("z_pulse", 32'(pulse), 32'h0008);
        chk("z_reg3",  cw(3), 32'd0);

        // Read in the same cycle as COMMIT of reg 7 sees the old value
        s_awaddr = 16'h001C; s_awvalid = 1'b1;
        s_wdata = 32'h77777777; s_wstrb = 4'hF; s_wvalid = 1'b1;
        tick(1);
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        s_araddr = 16'h001C; s_arvalid = 1'b1;
        tick(1);
        s_arvalid = 1'b0;
        chk("rc_rvalid", 32'(s_rvalid), 32'd1);
        chk("rc_rdata",  s_rdata, 32'd0);
        chk("rc_reg7",   cw(7), 32'h77777777);
        s_bready = 1'b1; s_rready = 1'b1;
        tick(1);
        s_bready = 1'b0; s_rready = 1'b0;

        // Back-pressure on B and R for 10 cycles
        s_awaddr = 16'h0014; s_awvalid = 1'b1;
        s_wdata = 32'hAAAA5555; s_wstrb = 4'hF; s_wvalid = 1'b1;
        s_araddr = 16'h0004; s_arvalid = 1'b1;
        tick(1);
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        tick(1);
        s_awaddr = 16'h0018; s_awvalid = 1'b1;
        s_wdata = 32'h00000066; s_wvalid = 1'b1;
        s_araddr = 16'h0018; s_arvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("bp_bvalid",  32'(s_bvalid), 32'd1);
            chk("bp_bresp",   32'(s_bresp), 32'd0);
            chk("bp_rvalid",  32'(s_rvalid), 32'd1);
            chk("bp_rdata",   s_rdata, 32'hDEADBEEF);
            chk("bp_rresp",   32'(s_rresp), 32'd0);
            chk("bp_awready", 32'(s_awready), 32'd0);
            chk("bp_wready",  32'(s_wready), 32'd0);
            chk("bp_arready", 32'(s_arready), 32'd0);
            tick(1);
        end
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        s_bready = 1'b1; s_rready = 1'b1;
        tick(1);
        s_bready = 1'b0; s_rready = 1'b0;
        chk("bp_bvalid_rel", 32'(s_bvalid), 32'd0);
        chk("bp_rvalid_rel", 32'(s_rvalid), 32'd0);
        chk("bp_reg5", cw(5), 32'hAAAA5555);
        chk("bp_reg6", cw(6), 32'd0);
        peek(16'h0014, data, resp);
        chk("bp_peek5", data, 32'hAAAA5555);
        poke(16'h0018, 32'h00000066, 4'hF, resp, pulse);
        chk("bp_poke6_resp",  32'(resp), 32'd0);
        chk("bp_poke6_pulse", 32'(pulse), 32'h0040);
        chk("bp_reg6_new", cw(6), 32'h00000066);

        // Reset landing on the COMMIT cycle of a write to reg 1
        s_awaddr = 16'h0004; s_awvalid = 1'b1;
        s_wdata = 32'h11111111; s_wstrb = 4'hF; s_wvalid = 1'b1;
        tick(1);
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("rs_reg1",   cw(1), 32'd0);
        chk("rs_any",    32'(|ctrl_q), 32'd0);
        chk("rs_bvalid", 32'(s_bvalid), 32'd0);
        chk("rs_pulse",  32'(wr_pulse), 32'd0);
        tick(2);
        chk("rs_bvalid_late", 32'(s_bvalid), 32'd0);
        peek(16'h0004, data, resp);
        chk("rs_peek1_data", data, 32'd0);
        chk("rs_peek1_resp", 32'(resp), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
